pipe_csel_adder: RTL and testbench
==================================

PIPE_CSEL_ADDER -- requirements
Module: pipe_csel_adder

Interface
REQ-001 Parameter W, 32, operand width in bits; the design SHALL support W >= 2.
REQ-002 Parameter GW, 8, carry-select group width; W SHALL be a multiple of GW, giving pipeline depth P = W/GW.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 X  input  W  operand 1, unsigned or two's complement.
REQ-006 Y  input  W  operand 2.
REQ-007 CI  input  1  carry-in; ignored when SUB=1.
REQ-008 SUB  input  1  1 = subtract (X - Y), 0 = add.
REQ-009 IV  input  1  input valid.
REQ-010 IR  output  1  input ready.
REQ-011 S  output  W+1  result; S[W] is carry-out (for subtract, S[W]=1 means no borrow).
REQ-012 OV  output  1  output valid.
REQ-013 OR  input  1  output ready.
REQ-014 V  output  1  signed overflow; present only under REQ-030.

Function
REQ-015 Effective operands SHALL be Ye = SUB ? ~Y : Y and Ce = SUB ? 1 : CI; result S = X + Ye + Ce over W+1 bits.
REQ-016 Stage k (k = 0..P-1) SHALL add group k of the operands (bits k*GW .. k*GW+GW-1) as two ripple sums, with carry 0 and carry 1 respectively.
REQ-017 Stage k SHALL select between the two sums, and between their carry-outs, using the carry registered out of stage k-1; stage 0 SHALL use Ce.
REQ-018 Operand groups above k SHALL be carried forward in stage registers; finished sum groups SHALL be carried forward so all W+1 bits align at the output.
REQ-019 Transfer in: a transfer SHALL occur on a rising edge with IV=1 and IR=1.
REQ-020 Transfer out: a transfer SHALL occur on a rising edge with OV=1 and OR=1.
REQ-021 Advance: adv = ~OV | OR, and IR SHALL equal adv combinationally.
REQ-022 When adv=1, every stage register and valid bit SHALL shift one stage, and the stage-0 valid bit SHALL load IV.
REQ-023 When adv=0, all stage registers SHALL hold, and S and OV SHALL remain stable.
REQ-024 Latency: an item accepted at edge t with adv continuously 1 SHALL present OV=1 with its result after edge t+P-1 (visible in cycle t+P).
REQ-025 Throughput SHALL be one item per cycle.
REQ-026 Results SHALL emerge in acceptance order, with no loss or duplication under any OR pattern.
REQ-027 Bubbles (IV=0) SHALL propagate as invalid slots, and the pipeline SHALL compact them whenever OV=0.
REQ-028 P=1 SHALL degenerate to a single registered carry-select stage with latency 1.

Reset
REQ-029 While RST=1: all valid bits SHALL be 0, OV=0, S=0, V=0, and IR=1. In-flight items asserted mid-operation SHALL be discarded, and no stale result SHALL appear after release.

Configuration
REQ-030 Macro PIPE_CSEL_ADDER_OVF_EN, when defined, SHALL add port V, pipelined with the same latency as S.
REQ-031 Under PIPE_CSEL_ADDER_OVF_EN, V SHALL be computed as (X[W-1] == Ye[W-1]) & (S[W-1] != X[W-1]).
REQ-032 When PIPE_CSEL_ADDER_OVF_EN is undefined, port V and its registers SHALL be absent, and all other behaviour SHALL be identical.

Verification (W=32, GW=8, P=4, OR=1 unless stated)
REQ-033 Full carry chain: X=0xFFFFFFFF, Y=0x00000001, CI=0, SUB=0 -> S=0x1_00000000, OV=1 exactly 4 cycles after acceptance, V=0.
REQ-034 Carry-in: X=0x12345678, Y=0x0000FFFF, CI=1 -> S=0x0_12355678.
REQ-035 Subtract with borrow: X=5, Y=7, SUB=1, CI=1 -> S=0x0_FFFFFFFE, V=0.
REQ-036 Signed overflow (macro on): X=0x7FFFFFFF, Y=1 -> S=0x0_80000000, V=1.
REQ-037 Backpressure: 16 back-to-back random items with OR random at 50% -> all 16 results match the reference model, in order.
REQ-038 Backpressure (continued): in the REQ-037 run, IR=0 in every cycle with OV=1 and OR=0, and S is stable across each such stall.
REQ-039 Reset mid-flight: accept 3 items, assert RST for 1 cycle -> OV=0 and S=0 immediately; with IV=0 after release, OV stays 0 for 10 cycles.

Source files
------------

// File: rtl/pipe_csel_adder_if.sv
// Operand/result handshake bundle for pipe_csel_adder.
// V exists only when PIPE_CSEL_ADDER_OVF_EN is defined.
interface pipe_csel_adder_if #(
    parameter int W = 32
);
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         CI;
    logic         SUB;
    logic         IV;
    logic         IR;
    logic [W:0]   S;
    logic         OV;
    logic         OR;
`ifdef PIPE_CSEL_ADDER_OVF_EN
    logic         V;

    modport master (
        output X, Y, CI, SUB, IV, OR,
        input  IR, S, OV, V
    );

    modport slave (
        input  X, Y, CI, SUB, IV, OR,
        output IR, S, OV, V
    );
`else
    modport master (
        output X, Y, CI, SUB, IV, OR,
        input  IR, S, OV
    );

    modport slave (
        input  X, Y, CI, SUB, IV, OR,
        output IR, S, OV
    );
`endif
endinterface

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor, one GW-bit group per stage.
// Define PIPE_CSEL_ADDER_OVF_EN to add the pipelined signed-overflow output V.
module pipe_csel_adder #(
    parameter int W  = 32,
    parameter int GW = 8
) (
    input logic              CLK,
    input logic              RST,
    pipe_csel_adder_if.slave io
);
    localparam int P = W / GW;

    if (W < 2 || GW < 1 || (W % GW) != 0) begin : g_bad_cfg
        $error("pipe_csel_adder: W must be >= 2 and a multiple of GW");
    end

    function automatic logic [GW:0] ripple(
        input logic [GW-1:0] a,
        input logic [GW-1:0] b,
        input logic          c
    );
        logic [GW:0] r;
        logic        cy;
        r  = '0;
        cy = c;
        for (int i = 0; i < GW; i++) begin
            r[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        r[GW] = cy;
        return r;
    endfunction

    logic [W-1:0]          ye;
    logic                  ce;
    logic                  adv;

    // xin/yin/cin/vin: what each stage sees from its upstream neighbour
    logic [P-1:0][W-1:0]   xin;
    logic [P-1:0][W-1:0]   yin;
    logic [P-1:0]          cin;
    logic [P-1:0]          vin;

    // sx holds finished sum groups below k and untouched X groups above
    logic [P-1:0][W-1:0]   sx_q, sx_d;
    // yr holds the not-yet-consumed Ye groups, shifted down to bit 0
    logic [P-1:0][W-1:0]   yr_q, yr_d;
    logic [P-1:0]          c_q, c_d;
    logic [P-1:0]          v_q, v_d;

    logic [GW:0]           s0, s1, sel;

`ifdef PIPE_CSEL_ADDER_OVF_EN
    logic                  vf_q, vf_d;
`endif

    always_comb begin
        ye  = io.SUB ? ~io.Y : io.Y;
        ce  = io.SUB | io.CI;
        adv = ~v_q[P-1] | io.OR;
    end

    for (genvar k = 0; k < P; k++) begin : g_link
        if (k == 0) begin : g_head
            assign xin[k] = io.X;
            assign yin[k] = ye;
            assign cin[k] = ce;
            assign vin[k] = io.IV;
        end else begin : g_body
            assign xin[k] = sx_q[k-1];
            assign yin[k] = yr_q[k-1];
            assign cin[k] = c_q[k-1];
            assign vin[k] = v_q[k-1];
        end
    end

    always_comb begin
        sx_d = '0;
        yr_d = '0;
        c_d  = '0;
        v_d  = '0;
        s0   = '0;
        s1   = '0;
        sel  = '0;
        for (int k = 0; k < P; k++) begin
            s0  = ripple(xin[k][k*GW +: GW], yin[k][GW-1:0], 1'b0);
            s1  = ripple(xin[k][k*GW +: GW], yin[k][GW-1:0], 1'b1);
            sel = cin[k] ? s1 : s0;
            sx_d[k] = xin[k];
            sx_d[k][k*GW +: GW] = sel[GW-1:0];
            c_d[k]  = sel[GW];
            v_d[k]  = vin[k];
            yr_d[k] = yin[k] >> GW;
        end
    end

`ifdef PIPE_CSEL_ADDER_OVF_EN
    // the last stage still sees X's sign bit and Ye's top group
    always_comb begin
        vf_d = (xin[P-1][W-1] == yin[P-1][GW-1])
             & (sx_d[P-1][W-1] != xin[P-1][W-1]);
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sx_q <= '0;
            yr_q <= '0;
            c_q  <= '0;
            v_q  <= '0;
`ifdef PIPE_CSEL_ADDER_OVF_EN
            vf_q <= 1'b0;
`endif
        end else if (adv) begin
            sx_q <= sx_d;
            yr_q <= yr_d;
            c_q  <= c_d;
            v_q  <= v_d;
`ifdef PIPE_CSEL_ADDER_OVF_EN
            vf_q <= vf_d;
`endif
        end
    end

    assign io.IR = adv;
    assign io.OV = v_q[P-1];
    assign io.S  = {c_q[P-1], sx_q[P-1]};
`ifdef PIPE_CSEL_ADDER_OVF_EN
    assign io.V  = vf_q;
`endif

    // nothing is left to consume after the final stage
    logic unused_yr;
    assign unused_yr = ^yr_q[P-1];

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Scoreboard bench for pipe_csel_adder: random and directed items
// against an arithmetic reference, with random output backpressure.
module tb_pipe_csel_adder;
    localparam int W  = 32;
    localparam int GW = 8;
    localparam int P  = W / GW;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pipe_csel_adder_if #(.W(W)) bus ();

    pipe_csel_adder #(.W(W), .GW(GW)) dut (
        .CLK(CLK),
        .RST(RST),
        .io (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit lat_chk = 1'b0;
    bit or_rand = 1'b0;

    logic [W+1:0] exp_q[$];
    int           due_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // {V, S}: plain wide arithmetic plus a signed range test
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic ci,
                                           input logic sub);
        logic [W-1:0] ye;
        logic         c;
        longint       u;
        longint       r;
        longint       mx;
        longint       mn;
        logic         ovf;
        ye  = sub ? ~y : y;
        c   = sub ? 1'b1 : ci;
        u   = longint'(x) + longint'(ye) + longint'(c);
        r   = longint'($signed(x)) + longint'($signed(ye)) + longint'(c);
        mx  = (longint'(1) <<< (W-1)) - 1;
        mn  = -(longint'(1) <<< (W-1));
        ovf = (r > mx) || (r < mn);
        return {ovf, u[W:0]};
    endfunction

    initial begin
        bus.OR = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            bus.OR = or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: every cycle with OV=1 must show the oldest expected item
    always @(negedge CLK) begin
        if (!RST && bus.OV === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out act=%h req=none", bus.S);
            end else begin
                check("S", bus.S, exp_q[0][W:0]);
`ifdef PIPE_CSEL_ADDER_OVF_EN
                check("V", bus.V, exp_q[0][W+1]);
`endif
                if (bus.OR !== 1'b1) begin
                    check("stall_IR", bus.IR, 0);
                end else begin
                    if (lat_chk) check("latency", cyc, due_q[0]);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sub);
        int n;
        @(posedge CLK);
        #1;
        bus.X   = x;
        bus.Y   = y;
        bus.CI  = ci;
        bus.SUB = sub;
        bus.IV  = 1'b1;
        n = 0;
        forever begin
            @(negedge CLK);
            if (bus.IR === 1'b1) begin
                exp_q.push_back(model(x, y, ci, sub));
                due_q.push_back(cyc + P);
                break;
            end
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout act=IR0 req=IR1");
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        bus.IV = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout act=%0d req=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.X   = '0;
        bus.Y   = '0;
        bus.CI  = 1'b0;
        bus.SUB = 1'b0;
        bus.IV  = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_OV", bus.OV, 0);
        check("rst_S", bus.S, 0);
        check("rst_IR", bus.IR, 1);
`ifdef PIPE_CSEL_ADDER_OVF_EN
        check("rst_V", bus.V, 0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;

        lat_chk = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        idle();
        drain();

        lat_chk = 1'b0;
        or_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send($urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle();
        drain();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) idle();
            send($urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle();
        drain();
        or_rand = 1'b0;

        for (int i = 0; i < 3; i++) begin
            send($urandom, $urandom, 1'b0, 1'b0);
        end
        @(posedge CLK);
        #1;
        bus.IV = 1'b0;
        RST    = 1'b1;
        exp_q.delete();
        due_q.delete();
        @(negedge CLK);
        check("midrst_OV", bus.OV, 0);
        check("midrst_S", bus.S, 0);
        check("midrst_IR", bus.IR, 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("postrst_OV", bus.OV, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
